// File: rtl/ecc_pkg.sv
// SEC-DED helper package: H-matrix column lookup, syndrome-to-bit mapping, error class.
// Pure functions and types, no latency.
// No flow control.
package ecc_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        CE    = 2'd1,
        DUE   = 2'd2
    } err_class_e;

    localparam int SYN_INVALID = -1;

    // Codeword bit k: k<r is check bit k, k==r is overall parity, k>r is data bit k-r-1.
    function automatic int unsigned h_col(int unsigned k, int unsigned data_w, int unsigned r);
        int unsigned c;
        c = 0;
        if (k < r) begin
            c = 32'd1 << k;
        end else if (k > r && k <= r + data_w) begin
            // Start at the data index offset past {1,2}, then skip each power of two passed.
            c = k - r + 2;
            for (int j = 2; j < 32; j++) begin
                if ((32'd1 << j) <= c) c = c + 1;
            end
        end
        return c;
    endfunction

    // Returns the codeword bit index whose column equals s, or SYN_INVALID.
    function automatic int syn_to_idx(int unsigned s, int unsigned data_w, int unsigned r);
        int unsigned msb;
        int unsigned off;
        int          idx;
        msb = 0;
        idx = SYN_INVALID;
        for (int j = 0; j < 32; j++) begin
            if (s[j]) msb = j;
        end
        off = s - msb - 2;
        if (s == 0 || s >= (32'd1 << r)) begin
            idx = SYN_INVALID;
        end else if ((s & (s - 1)) == 0) begin
            idx = int'(msb);
        end else if (off < data_w) begin
            idx = int'(r + 1 + off);
        end
        return idx;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of a {data, check} codeword.
// Zero latency.
// No flow control; with check bits tied to zero it yields the encoder's check bits.
module secded_syndrome
    import ecc_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CHK_W  = 9
) (
    input  logic [DATA_W+CHK_W-1:0] codeword,
    output logic [CHK_W-2:0]        syn,
    output logic                    parity
);
    localparam int R = CHK_W - 1;
    localparam int N = DATA_W + CHK_W;

    logic [R-1:0] term [N];

    generate
        for (genvar k = 0; k < N; k++) begin : g_col
            localparam int unsigned COL = h_col(k, DATA_W, R);
            assign term[k] = codeword[k] ? COL[R-1:0] : '0;
        end
    endgenerate

    always_comb begin
        syn = '0;
        for (int k = 0; k < N; k++) begin
            syn = syn ^ term[k];
        end
    end

    assign parity = ^codeword;

endmodule

// File: rtl/secded_decoder_pipe.sv
// Two-stage SEC-DED decoder with run-time correct enable, CE/DUE counters and first-error log.
// Latency 2 cycles from input handshake to out_valid; one word per cycle.
// Each stage advances when the next is empty or draining; outputs held while out_ready=0.
module secded_decoder_pipe
    import ecc_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CHK_W  = 9,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W+CHK_W-1:0] in_codeword,
    input  logic                    corr_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_ce,
    output logic                    out_due,
    output logic [CHK_W-1:0]        out_syndrome,
    output logic [CNT_W-1:0]        ce_cnt,
    output logic [CNT_W-1:0]        due_cnt,
    input  logic                    cnt_clr,
    output logic                    log_valid,
    output logic [CHK_W-1:0]        log_syndrome,
    output logic                    log_due,
    input  logic                    log_clr
);
    localparam int R = CHK_W - 1;
    localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    generate
        if (DATA_W > (1 << R) - R - 1) begin : g_width_check
            $error("secded_decoder_pipe: DATA_W too large for CHK_W");
        end
    endgenerate

    logic              s1_valid;
    logic              s2_valid;
    logic              s2_adv;
    logic              s1_corr;
    logic [DATA_W-1:0] s1_data;
    logic [CHK_W-1:0]  s1_syn;
    logic [R-1:0]      in_s;
    logic              in_p;
    err_class_e        cls;
    logic [DATA_W-1:0] flip;
    int                idx;
    logic              hs;
    logic              ev_ce;
    logic              ev_due;

    secded_syndrome #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syndrome (
        .codeword (in_codeword),
        .syn      (in_s),
        .parity   (in_p)
    );

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_corr  <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                s1_data <= in_codeword[DATA_W+CHK_W-1:CHK_W];
                s1_syn  <= {in_p, in_s};
                s1_corr <= corr_en;
            end
        end
    end

    // A nonzero syndrome with even parity, or any error in detect-only mode, is uncorrectable.
    always_comb begin
        idx  = syn_to_idx(32'(s1_syn[R-1:0]), DATA_W, R);
        cls  = CLEAN;
        flip = '0;
        if (s1_syn == '0) begin
            cls = CLEAN;
        end else if (!s1_corr || !s1_syn[R]) begin
            cls = DUE;
        end else if (s1_syn[R-1:0] == '0) begin
            cls = CE;
        end else if (idx != SYN_INVALID) begin
            cls = CE;
            if (idx > R) flip = DATA_ONE << (idx - R - 1);
        end else begin
            cls = DUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            out_data     <= '0;
            out_ce       <= 1'b0;
            out_due      <= 1'b0;
            out_syndrome <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= s1_data ^ flip;
                out_ce       <= (cls == CE);
                out_due      <= (cls == DUE);
                out_syndrome <= s1_syn;
            end
        end
    end

    assign hs     = out_valid && out_ready;
    assign ev_ce  = hs && out_ce;
    assign ev_due = hs && out_due;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_cnt  <= '0;
            due_cnt <= '0;
        end else begin
            if (cnt_clr)                          ce_cnt <= ev_ce ? CNT_ONE : '0;
            else if (ev_ce && ce_cnt != CNT_MAX)  ce_cnt <= ce_cnt + CNT_ONE;
            if (cnt_clr)                          due_cnt <= ev_due ? CNT_ONE : '0;
            else if (ev_due && due_cnt != CNT_MAX) due_cnt <= due_cnt + CNT_ONE;
        end
    end

    // A clear in the same cycle as an error re-arms and captures that error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log_valid    <= 1'b0;
            log_syndrome <= '0;
            log_due      <= 1'b0;
        end else if ((ev_ce || ev_due) && (!log_valid || log_clr)) begin
            log_valid    <= 1'b1;
            log_syndrome <= out_syndrome;
            log_due      <= out_due;
        end else if (log_clr) begin
            log_valid    <= 1'b0;
            log_syndrome <= '0;
            log_due      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Randomized scoreboard bench for secded_decoder_pipe; a second instance with CNT_W=2 shares the stimulus.
module tb_secded_decoder_pipe;
    localparam int DW = 128;
    localparam int CW = 9;
    localparam int RR = CW - 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          ce;
        logic          due;
        logic [CW-1:0] syn;
    } exp_t;

    logic clk, rst;
    logic in_valid, corr_en, out_ready, cnt_clr, log_clr;
    logic [DW+CW-1:0] in_codeword;
    logic in_ready, out_valid, out_ce, out_due, log_valid, log_due;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_syndrome, log_syndrome;
    logic [15:0] ce_cnt, due_cnt;
    logic s_in_ready, s_out_valid, s_out_ce, s_out_due, s_log_valid, s_log_due;
    logic [DW-1:0] s_out_data;
    logic [CW-1:0] s_out_syndrome, s_log_syndrome;
    logic [1:0] s_ce_cnt, s_due_cnt;

    secded_decoder_pipe #(.DATA_W(DW), .CHK_W(CW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_codeword(in_codeword),
        .corr_en(corr_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ce(out_ce), .out_due(out_due), .out_syndrome(out_syndrome), .ce_cnt(ce_cnt),
        .due_cnt(due_cnt), .cnt_clr(cnt_clr), .log_valid(log_valid), .log_syndrome(log_syndrome),
        .log_due(log_due), .log_clr(log_clr)
    );

    secded_decoder_pipe #(.DATA_W(DW), .CHK_W(CW), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_codeword(in_codeword),
        .corr_en(corr_en), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_ce(s_out_ce), .out_due(s_out_due), .out_syndrome(s_out_syndrome), .ce_cnt(s_ce_cnt),
        .due_cnt(s_due_cnt), .cnt_clr(cnt_clr), .log_valid(s_log_valid), .log_syndrome(s_log_syndrome),
        .log_due(s_log_due), .log_clr(log_clr)
    );

    int n_tests = 0;
    int n_fail = 0;
    exp_t q[$];
    logic [RR-1:0] col_tab [DW];
    int m_ce, m_due, m_ce_s, m_due_s;
    bit m_log_v;
    logic [CW-1:0] m_log_syn;
    bit m_log_due;
    bit stall_prev;
    logic [139:0] held;
    int ready_mode = 1;
    int stall_cycles = 0;
    bit clr_force = 0;
    bit rand_clr = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW+CW-1:0] encode(logic [DW-1:0] d);
        logic [RR-1:0] s;
        s = '0;
        for (int i = 0; i < DW; i++) if (d[i]) s ^= col_tab[i];
        return {d, ^{d, s}, s};
    endfunction

    // Reference decode straight from the H-matrix definition by table search.
    function automatic exp_t model(logic [DW+CW-1:0] cw, logic corr);
        exp_t e;
        logic [RR-1:0] s;
        logic p;
        int hit;
        s = cw[RR-1:0];
        for (int i = 0; i < DW; i++) if (cw[CW+i]) s ^= col_tab[i];
        p = ^cw;
        hit = -1;
        for (int i = 0; i < DW; i++) if (col_tab[i] == s) hit = i;
        e.data = cw[DW+CW-1:CW];
        e.syn  = {p, s};
        e.ce   = 0;
        e.due  = 0;
        if ({p, s} == '0) e.ce = 0;
        else if (!corr || !p) e.due = 1;
        else if ($countones(s) <= 1) e.ce = 1;
        else if (hit >= 0) begin e.ce = 1; e.data[hit] = ~e.data[hit]; end
        else e.due = 1;
        return e;
    endfunction

    function automatic int upd(int c, bit ev, bit clr, int maxv);
        if (clr) return ev ? 1 : 0;
        if (ev && c < maxv) return c + 1;
        return c;
    endfunction

    function automatic logic [DW+CW-1:0] flipb(logic [DW+CW-1:0] cw, int k);
        logic [DW+CW-1:0] r;
        r = cw;
        r[k] = ~r[k];
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW; i += 32) d[i+:32] = $urandom;
        return d;
    endfunction

    task automatic send(logic [DW+CW-1:0] cw, logic corr);
        bit acc;
        int guard;
        in_valid = 1; in_codeword = cw; corr_en = corr; acc = 0; guard = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
            if (!acc && guard > 200) begin
                chk("send_timeout", in_ready, 1);
                break;
            end
        end
        if (acc) q.push_back(model(cw, corr));
        in_valid = 0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    // Out_ready / clear drivers, updated 2 time units after each edge.
    initial begin
        out_ready = 1; cnt_clr = 0; log_clr = 0;
        forever begin
            @(posedge clk); #2;
            if (stall_cycles > 0) begin
                out_ready = 0;
                stall_cycles--;
            end else begin
                case (ready_mode)
                    0: out_ready = ($urandom_range(0, 3) != 0);
                    1: out_ready = 1;
                    default: out_ready = 0;
                endcase
            end
            cnt_clr = clr_force || (rand_clr && $urandom_range(0, 63) == 0);
            log_clr = rand_clr && ($urandom_range(0, 15) == 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit ev_ce, ev_due, exp_rdy;
        if (rst) begin
            stall_prev = 0;
        end else begin
            ev_ce = 0; ev_due = 0;
            e = '0;
            exp_rdy = (q.size() < 2) || out_ready;
            chk("in_ready", in_ready, exp_rdy);
            chk("w2_in_ready", s_in_ready, exp_rdy);
            chk("ce_cnt", ce_cnt, m_ce);
            chk("due_cnt", due_cnt, m_due);
            chk("w2_ce_cnt", s_ce_cnt, m_ce_s);
            chk("w2_due_cnt", s_due_cnt, m_due_s);
            chk("log_valid", log_valid, m_log_v);
            if (m_log_v) begin
                chk("log_entry", {log_syndrome, log_due}, {m_log_syn, m_log_due});
                chk("w2_log_entry", {s_log_valid, s_log_syndrome, s_log_due}, {1'b1, m_log_syn, m_log_due});
            end
            if (stall_prev)
                chk("hold_stable", {out_valid, out_data, out_ce, out_due, out_syndrome}, held);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    e = q[0];
                    chk("out_data", out_data, e.data);
                    chk("out_flags", {out_ce, out_due}, {e.ce, e.due});
                    chk("out_syndrome", out_syndrome, e.syn);
                    chk("w2_out", {s_out_valid, s_out_data, s_out_ce, s_out_due, s_out_syndrome},
                        {1'b1, e.data, e.ce, e.due, e.syn});
                    if (out_ready) begin
                        void'(q.pop_front());
                        ev_ce = e.ce;
                        ev_due = e.due;
                    end
                end
            end
            m_ce    = upd(m_ce, ev_ce, cnt_clr, 65535);
            m_due   = upd(m_due, ev_due, cnt_clr, 65535);
            m_ce_s  = upd(m_ce_s, ev_ce, cnt_clr, 3);
            m_due_s = upd(m_due_s, ev_due, cnt_clr, 3);
            if ((ev_ce || ev_due) && (!m_log_v || log_clr)) begin
                m_log_v = 1; m_log_syn = e.syn; m_log_due = ev_due;
            end else if (log_clr) begin
                m_log_v = 0;
            end
            stall_prev = out_valid && !out_ready;
            held = {out_valid, out_data, out_ce, out_due, out_syndrome};
        end
    end

    initial begin
        int v;
        int nf;
        logic [DW+CW-1:0] cw;
        v = 3;
        for (int i = 0; i < DW; i++) begin
            while ((v & (v - 1)) == 0) v++;
            col_tab[i] = v[RR-1:0];
            v++;
        end
        m_ce = 0; m_due = 0; m_ce_s = 0; m_due_s = 0; m_log_v = 0; m_log_syn = '0; m_log_due = 0;
        rst = 1; in_valid = 0; in_codeword = '0; corr_en = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_regs", {out_data, out_ce, out_due, out_syndrome}, 0);
        chk("rst_counters", {ce_cnt, due_cnt, s_ce_cnt, s_due_cnt}, 0);
        chk("rst_log", {log_valid, log_syndrome, log_due}, 0);
        rst = 0;
        @(posedge clk); #1;

        // Clean zero word and its 2-cycle latency.
        send('0, 1);
        @(negedge clk); chk("latency_cycle1", out_valid, 0);
        @(negedge clk); chk("latency_cycle2", out_valid, 1);
        @(posedge clk); #1;
        drain();

        send(flipb('0, CW + 2), 1);
        drain();
        chk("ce_cnt_first", ce_cnt, 1);
        chk("log_first", {log_valid, log_syndrome, log_due}, {1'b1, 9'h106, 1'b0});

        send(flipb(flipb('0, CW + 0), CW + 1), 1);
        drain();
        chk("due_cnt_first", due_cnt, 1);
        chk("log_unchanged", {log_valid, log_syndrome, log_due}, {1'b1, 9'h106, 1'b0});

        send(flipb('0, CW + 2), 0);
        send(flipb('0, 8), 1);
        drain();
        chk("counts_directed", {ce_cnt, due_cnt}, {16'd2, 16'd2});

        // Back-to-back stream with a 3-cycle stall after two words.
        for (int i = 0; i < 8; i++) begin
            if (i == 2) stall_cycles = 3;
            cw = encode(rand_data());
            if (i % 2 == 1) cw = flipb(cw, $urandom_range(0, DW + CW - 1));
            send(cw, 1);
        end
        drain();

        // Counter clear coinciding with a CE handshake.
        ready_mode = 2;
        send(flipb(encode(rand_data()), CW + 5), 1);
        for (int g = 0; g < 20 && !out_valid; g++) begin
            @(posedge clk); #1;
        end
        chk("cnt_clr_setup_valid", out_valid, 1);
        @(posedge clk); #1;
        ready_mode = 1; clr_force = 1;
        @(posedge clk); #1;
        clr_force = 0;
        chk("cnt_clr_with_ce", ce_cnt, 1);
        drain();

        // Randomized traffic with backpressure and random clears.
        ready_mode = 0; rand_clr = 1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            cw = encode(rand_data());
            nf = $urandom_range(0, 9);
            nf = (nf < 3) ? 0 : (nf < 6) ? 1 : (nf < 8) ? 2 : 3;
            for (int f = 0; f < nf; f++) cw = flipb(cw, $urandom_range(0, DW + CW - 1));
            send(cw, $urandom_range(0, 7) != 0);
        end
        rand_clr = 0; ready_mode = 1;
        drain();

        for (int n = 0; n < 6; n++) send(flipb(encode(rand_data()), CW + n * 7), 1);
        drain();
        chk("w2_ce_saturated", s_ce_cnt, 3);

        // Asynchronous reset with two words in flight.
        ready_mode = 2;
        send(encode(rand_data()), 1);
        send(flipb(encode(rand_data()), CW + 1), 1);
        @(posedge clk); #1;
        chk("pre_rst_full", {out_valid, in_ready}, 2'b10);
        #2 rst = 1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_counters", {ce_cnt, due_cnt, s_ce_cnt, s_due_cnt}, 0);
        chk("mid_rst_log", {log_valid, out_data}, 0);
        q.delete();
        m_ce = 0; m_due = 0; m_ce_s = 0; m_due_s = 0; m_log_v = 0;
        @(posedge clk); #1;
        rst = 0; ready_mode = 1;
        @(posedge clk); #1;
        for (int n = 0; n < 4; n++) send(flipb(encode(rand_data()), $urandom_range(0, DW + CW - 1)), 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
